// File: rtl/icache_pkg.sv
// icache_pkg: shared constants, FSM state type and address-split helpers for the instruction cache
package icache_pkg;

    localparam int BLOCK_WORDS = 8;
    localparam int OFFSET_BITS = 5;
    localparam int WORD_BITS   = 3;

    typedef enum logic {
        IDLE,
        FILL
    } state_e;

    // Word position of a fetch address inside its 32-byte block
    function automatic logic [WORD_BITS-1:0] addr_word(input logic [31:0] a);
        return a[OFFSET_BITS-1:2];
    endfunction

    // Block-aligned form of a fetch address, used as the fill address
    function automatic logic [31:0] addr_align(input logic [31:0] a);
        return {a[31:OFFSET_BITS], {OFFSET_BITS{1'b0}}};
    endfunction

    // Select one 32-bit word out of a 256-bit line
    function automatic logic [31:0] block_word(input logic [32*BLOCK_WORDS-1:0] blk,
                                               input logic [WORD_BITS-1:0] w);
        return blk[32*w +: 32];
    endfunction

endpackage

// File: rtl/icache_line_store.sv
// icache_line_store: data, tag and valid arrays with one combinational read port and one full-line write port
module icache_line_store
    import icache_pkg::*;
#(
    parameter int NUM_LINES = 32,
    parameter int IDX_BITS  = $clog2(NUM_LINES),
    parameter int TAG_BITS  = 27 - IDX_BITS
) (
    input  logic                       CLK,
    input  logic                       RESET,
    input  logic [IDX_BITS-1:0]        rd_idx_i,
    output logic [32*BLOCK_WORDS-1:0]  rd_data_o,
    output logic [TAG_BITS-1:0]        rd_tag_o,
    output logic                       rd_valid_o,
    input  logic                       wr_en_i,
    input  logic [IDX_BITS-1:0]        wr_idx_i,
    input  logic [TAG_BITS-1:0]        wr_tag_i,
    input  logic [32*BLOCK_WORDS-1:0]  wr_data_i,
    input  logic                       wr_set_valid_i,
    input  logic                       clear_all_i
);

    logic [32*BLOCK_WORDS-1:0] data_q [NUM_LINES];
    logic [TAG_BITS-1:0]       tag_q  [NUM_LINES];
    logic [NUM_LINES-1:0]      valid_q;

    assign rd_data_o  = data_q[rd_idx_i];
    assign rd_tag_o   = tag_q[rd_idx_i];
    assign rd_valid_o = valid_q[rd_idx_i];

    // Valid bits: only state that is reset; clear-all overrides a same-cycle write
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            valid_q <= '0;
        end else if (clear_all_i) begin
            valid_q <= '0;
        end else if (wr_en_i) begin
            valid_q[wr_idx_i] <= wr_set_valid_i;
        end
    end

    // Data and tag payload: written on fill, never reset
    always_ff @(posedge CLK) begin
        if (wr_en_i) begin
            data_q[wr_idx_i] <= wr_data_i;
            tag_q[wr_idx_i]  <= wr_tag_i;
        end
    end

endmodule

// File: rtl/icache_direct.sv
// icache_direct: direct-mapped read-only instruction cache with combinational hits and single-block fills
module icache_direct
    import icache_pkg::*;
#(
    parameter int NUM_LINES = 32,
    parameter int TAG_BITS  = 27 - $clog2(NUM_LINES)
) (
    input  logic                       CLK,
    input  logic                       RESET,
    input  logic [31:0]                Instr_address_2IC,
    output logic [31:0]                Instr1_fIC,
    output logic [31:0]                Instr2_fIC,
    output logic                       Instr1_valid_fIC,
    output logic                       Instr2_valid_fIC,
    input  logic                       Flush,
    output logic [31:0]                Instr_address_2IM,
    output logic                       iBlkRead,
    input  logic [32*BLOCK_WORDS-1:0]  block_read_fIM,
    input  logic                       block_read_fIM_valid,
    output logic [31:0]                miss_count
);

    localparam int IDX_BITS = $clog2(NUM_LINES);

    state_e                    state_q, state_d;
    logic [31:0]               addr_q, addr_d;
    logic [31:0]               miss_count_q, miss_count_d;
    logic                      flushed_q, flushed_d;
    logic                      wr_en, wr_set_valid;
    logic [32*BLOCK_WORDS-1:0] rd_data;
    logic [TAG_BITS-1:0]       rd_tag;
    logic                      rd_valid;
    logic [WORD_BITS-1:0]      word;
    logic                      hit;

    assign word = addr_word(Instr_address_2IC);
    assign hit  = (state_q == IDLE) && rd_valid &&
                  (rd_tag == Instr_address_2IC[31 -: TAG_BITS]);

    icache_line_store #(
        .NUM_LINES (NUM_LINES),
        .IDX_BITS  (IDX_BITS),
        .TAG_BITS  (TAG_BITS)
    ) u_store (
        .CLK            (CLK),
        .RESET          (RESET),
        .rd_idx_i       (Instr_address_2IC[OFFSET_BITS +: IDX_BITS]),
        .rd_data_o      (rd_data),
        .rd_tag_o       (rd_tag),
        .rd_valid_o     (rd_valid),
        .wr_en_i        (wr_en),
        .wr_idx_i       (addr_q[OFFSET_BITS +: IDX_BITS]),
        .wr_tag_i       (addr_q[31 -: TAG_BITS]),
        .wr_data_i      (block_read_fIM),
        .wr_set_valid_i (wr_set_valid),
        .clear_all_i    (Flush)
    );

    // Lookup result muxing; the second word never crosses into the next line
    assign Instr1_valid_fIC  = hit;
    assign Instr2_valid_fIC  = hit && (word != 3'd7);
    assign Instr1_fIC        = Instr1_valid_fIC ? block_word(rd_data, word) : '0;
    assign Instr2_fIC        = Instr2_valid_fIC ? block_word(rd_data, word + 3'd1) : '0;
    assign iBlkRead          = (state_q == FILL);
    assign Instr_address_2IM = addr_q;
    assign miss_count        = miss_count_q;

    // State, fill address, miss counter and flush-during-fill marker
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            state_q      <= IDLE;
            addr_q       <= '0;
            miss_count_q <= '0;
            flushed_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            addr_q       <= addr_d;
            miss_count_q <= miss_count_d;
            flushed_q    <= flushed_d;
        end
    end

    // Next state: start a fill on an IDLE miss, install the line when memory answers;
    // a flush seen at any point of the fill keeps the installed line invalid
    always_comb begin
        state_d      = state_q;
        addr_d       = addr_q;
        miss_count_d = miss_count_q;
        flushed_d    = flushed_q;
        wr_en        = 1'b0;
        wr_set_valid = 1'b0;
        if (state_q == IDLE) begin
            if (!hit) begin
                state_d      = FILL;
                addr_d       = addr_align(Instr_address_2IC);
                miss_count_d = miss_count_q + 32'd1;
                flushed_d    = 1'b0;
            end
        end else begin
            if (Flush) begin
                flushed_d = 1'b1;
            end
            if (block_read_fIM_valid) begin
                wr_en        = 1'b1;
                wr_set_valid = !(flushed_q || Flush);
                state_d      = IDLE;
            end
        end
    end

endmodule

// File: tb/tb_icache_direct.sv
// tb_icache_direct: directed table and sequence checks of the direct-mapped instruction cache
module tb_icache_direct;

    logic         CLK = 1'b0;
    logic         RESET = 1'b0;
    logic [31:0]  Instr_address_2IC = 32'h0;
    logic [31:0]  Instr1_fIC, Instr2_fIC, Instr_address_2IM, miss_count;
    logic         Instr1_valid_fIC, Instr2_valid_fIC, iBlkRead;
    logic         Flush = 1'b0;
    logic [255:0] block_read_fIM = '0;
    logic         block_read_fIM_valid = 1'b0;

    int total = 0;
    int bad = 0;
    int mem_lat = 3;

    icache_direct dut (
        .CLK                  (CLK),
        .RESET                (RESET),
        .Instr_address_2IC    (Instr_address_2IC),
        .Instr1_fIC           (Instr1_fIC),
        .Instr2_fIC           (Instr2_fIC),
        .Instr1_valid_fIC     (Instr1_valid_fIC),
        .Instr2_valid_fIC     (Instr2_valid_fIC),
        .Flush                (Flush),
        .Instr_address_2IM    (Instr_address_2IM),
        .iBlkRead             (iBlkRead),
        .block_read_fIM       (block_read_fIM),
        .block_read_fIM_valid (block_read_fIM_valid),
        .miss_count           (miss_count)
    );

    always #5 CLK = ~CLK;

    // Memory image: block b (address bits [16:5]) holds words 0x1000 + 16*b + i
    function automatic logic [255:0] blk(input logic [31:0] a);
        logic [255:0] r;
        for (int i = 0; i < 8; i++)
            r[32*i +: 32] = 32'h1000 + ((a >> 5) & 32'hFFF) * 16 + i;
        return r;
    endfunction

    // Memory responder: answers a block read after mem_lat cycles of iBlkRead
    initial begin
        int cnt;
        cnt = 0;
        forever begin
            @(negedge CLK);
            if (iBlkRead) begin
                cnt++;
                if (cnt >= mem_lat) begin
                    block_read_fIM_valid = 1'b1;
                    block_read_fIM = blk(Instr_address_2IM);
                    cnt = 0;
                end else begin
                    block_read_fIM_valid = 1'b0;
                end
            end else begin
                block_read_fIM_valid = 1'b0;
                cnt = 0;
            end
        end
    end

    typedef struct {
        logic [31:0] pc;
        logic        v1;
        logic [31:0] i1;
        logic        v2;
        logic [31:0] i2;
        logic        rd;
        logic [31:0] aim;
        logic [31:0] mc;
    } vec_t;

    vec_t tv[18];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", nm, act, exp);
        end
    endtask

    task automatic check_out(input string nm, input logic v1, input logic [31:0] i1,
                             input logic v2, input logic [31:0] i2, input logic rd,
                             input logic [31:0] aim, input logic [31:0] mc);
        chk({nm, ".v1"}, {31'b0, Instr1_valid_fIC}, {31'b0, v1});
        chk({nm, ".i1"}, Instr1_fIC, i1);
        chk({nm, ".v2"}, {31'b0, Instr2_valid_fIC}, {31'b0, v2});
        chk({nm, ".i2"}, Instr2_fIC, i2);
        chk({nm, ".rd"}, {31'b0, iBlkRead}, {31'b0, rd});
        chk({nm, ".aim"}, Instr_address_2IM, aim);
        chk({nm, ".mc"}, miss_count, mc);
    endtask

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    // Step until the current fill has been installed, bounded
    task automatic wait_done(input string nm);
        int n;
        n = 0;
        while (iBlkRead && n < 20) begin
            step();
            n++;
        end
        total++;
        if (iBlkRead) begin
            bad++;
            $display("FAIL %s fill timeout got=busy exp=idle", nm);
        end
    endtask

    initial begin
        int n;
        tv[0]  = '{32'h00400000, 0, 32'h0,    0, 32'h0,    0, 32'h0,        0};
        tv[1]  = '{32'h00400000, 0, 32'h0,    0, 32'h0,    1, 32'h00400000, 1};
        tv[2]  = '{32'h00400000, 0, 32'h0,    0, 32'h0,    1, 32'h00400000, 1};
        tv[3]  = '{32'h00400000, 0, 32'h0,    0, 32'h0,    1, 32'h00400000, 1};
        tv[4]  = '{32'h00400000, 1, 32'h1000, 1, 32'h1001, 0, 32'h00400000, 1};
        tv[5]  = '{32'h0040001C, 1, 32'h1007, 0, 32'h0,    0, 32'h00400000, 1};
        tv[6]  = '{32'h00400008, 1, 32'h1002, 1, 32'h1003, 0, 32'h00400000, 1};
        tv[7]  = '{32'h00400400, 0, 32'h0,    0, 32'h0,    0, 32'h00400000, 1};
        tv[8]  = '{32'h00400400, 0, 32'h0,    0, 32'h0,    1, 32'h00400400, 2};
        tv[9]  = '{32'h00400400, 0, 32'h0,    0, 32'h0,    1, 32'h00400400, 2};
        tv[10] = '{32'h00400400, 0, 32'h0,    0, 32'h0,    1, 32'h00400400, 2};
        tv[11] = '{32'h00400400, 1, 32'h1200, 1, 32'h1201, 0, 32'h00400400, 2};
        tv[12] = '{32'h00400000, 0, 32'h0,    0, 32'h0,    0, 32'h00400400, 2};
        tv[13] = '{32'h00400000, 0, 32'h0,    0, 32'h0,    1, 32'h00400000, 3};
        tv[14] = '{32'h00400000, 0, 32'h0,    0, 32'h0,    1, 32'h00400000, 3};
        tv[15] = '{32'h00400000, 0, 32'h0,    0, 32'h0,    1, 32'h00400000, 3};
        tv[16] = '{32'h00400004, 1, 32'h1001, 1, 32'h1002, 0, 32'h00400000, 3};
        tv[17] = '{32'h00400003, 1, 32'h1000, 1, 32'h1001, 0, 32'h00400000, 3};

        // Reset state: every lookup misses, everything reads zero
        Instr_address_2IC = 32'h00400000;
        repeat (2) @(posedge CLK);
        #1;
        check_out("reset", 0, 0, 0, 0, 0, 0, 0);
        RESET = 1'b1;

        // Cold miss, line boundary and conflict eviction, one vector per cycle
        for (int i = 0; i < 18; i++) begin
            Instr_address_2IC = tv[i].pc;
            #1;
            check_out($sformatf("vec%0d", i), tv[i].v1, tv[i].i1, tv[i].v2, tv[i].i2,
                      tv[i].rd, tv[i].aim, tv[i].mc);
            step();
        end

        // Flush coinciding with fill completion of 0x00400020
        Instr_address_2IC = 32'h00400020;
        #1;
        chk("flfill.miss", {31'b0, Instr1_valid_fIC}, 32'd0);
        n = 0;
        do begin
            @(negedge CLK);
            #1;
            n++;
        end while (!block_read_fIM_valid && n < 20);
        chk("flfill.memvalid", {31'b0, block_read_fIM_valid}, 32'd1);
        Flush = 1'b1;
        step();
        Flush = 1'b0;
        #1;
        check_out("flfill.after", 0, 0, 0, 0, 0, 32'h00400020, 4);
        step();
        chk("flfill.refill_mc", miss_count, 32'd5);
        wait_done("flfill.refill");
        check_out("flfill.hit20", 1, 32'h1010, 1, 32'h1011, 0, 32'h00400020, 5);
        Instr_address_2IC = 32'h00400000;
        #1;
        chk("flfill.miss00", {31'b0, Instr1_valid_fIC}, 32'd0);
        step();
        chk("flfill.mc00", miss_count, 32'd6);
        wait_done("flfill.refill00");

        // PC moves away during a fill; both lines usable afterwards
        Instr_address_2IC = 32'h00400040;
        #1;
        chk("pcchg.miss", {31'b0, Instr1_valid_fIC}, 32'd0);
        step();
        Instr_address_2IC = 32'h00400000;
        #1;
        check_out("pcchg.fill", 0, 0, 0, 0, 1, 32'h00400040, 7);
        wait_done("pcchg.fill");
        check_out("pcchg.hit00", 1, 32'h1000, 1, 32'h1001, 0, 32'h00400040, 7);
        Instr_address_2IC = 32'h00400040;
        #1;
        check_out("pcchg.hit40", 1, 32'h1020, 1, 32'h1021, 0, 32'h00400040, 7);

        // Single-cycle memory latency: hit two cycles after the miss
        mem_lat = 1;
        Instr_address_2IC = 32'h00400060;
        #1;
        chk("lat1.miss", {31'b0, Instr1_valid_fIC}, 32'd0);
        step();
        check_out("lat1.fill", 0, 0, 0, 0, 1, 32'h00400060, 8);
        step();
        check_out("lat1.hit", 1, 32'h1030, 1, 32'h1031, 0, 32'h00400060, 8);

        // Flush in IDLE: still hits in the flush cycle, misses on the next
        Instr_address_2IC = 32'h00400000;
        Flush = 1'b1;
        #1;
        check_out("idleflush.same", 1, 32'h1000, 1, 32'h1001, 0, 32'h00400060, 8);
        step();
        Flush = 1'b0;
        #1;
        chk("idleflush.next", {31'b0, Instr1_valid_fIC}, 32'd0);
        step();
        wait_done("idleflush.refill");
        check_out("idleflush.hit", 1, 32'h1000, 1, 32'h1001, 0, 32'h00400000, 9);

        // Reset in the middle of a fill aborts it
        mem_lat = 3;
        Instr_address_2IC = 32'h00400080;
        #1;
        step();
        chk("rstfill.rd", {31'b0, iBlkRead}, 32'd1);
        RESET = 1'b0;
        #1;
        check_out("rstfill.during", 0, 0, 0, 0, 0, 0, 0);
        @(negedge CLK);
        #1;
        RESET = 1'b1;
        #1;
        check_out("rstfill.release", 0, 0, 0, 0, 0, 0, 0);
        step();
        check_out("rstfill.refill", 0, 0, 0, 0, 1, 32'h00400080, 1);
        wait_done("rstfill.refill");
        check_out("rstfill.hit", 1, 32'h1040, 1, 32'h1041, 0, 32'h00400080, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/icache_direct.md
# icache_direct

Direct-mapped, read-only instruction cache between the IF stage and instruction memory. Replaces the pass-through path in which IF drives the memory address and takes `Instr1_fIM` straight back. Hits return instructions combinationally in the same cycle. Misses fetch one 256-bit block over the block-read port while holding IF stalled.

## Interface
Parameters:
- `NUM_LINES`, default 32: number of cache lines; must be a power of two, ≥ 2.
- `TAG_BITS`, default `27 - log2(NUM_LINES)`: derived; do not override.

Ports:
- `CLK` in 1: the single clock. All state updates on the rising edge.
- `RESET` in 1: reset, asynchronous, active-low (asserted at 0).
- `Instr_address_2IC` in 32: fetch PC from IF; bits [1:0] are ignored.
- `Instr1_fIC` out 32: instruction at `Instr_address_2IC`.
- `Instr2_fIC` out 32: instruction at `Instr_address_2IC + 4`, for superscalar fetch.
- `Instr1_valid_fIC` out 1: `Instr1_fIC` is valid this cycle. When 0, IF must stall.
- `Instr2_valid_fIC` out 1: `Instr2_fIC` is valid; it never crosses a line boundary.
- `Flush` in 1: invalidate all lines. Driven from the SYS path.
- `Instr_address_2IM` out 32: block-aligned fill address.
- `iBlkRead` out 1: block read request to instruction memory.
- `block_read_fIM` in 256: fill data. Word i occupies bits [32i+31:32i].
- `block_read_fIM_valid` in 1: fill data valid this cycle.
- `miss_count` out 32: number of fills started; wraps modulo 2^32.

## Operation
- Address split: offset = addr[4:0]; word = addr[4:2]; index = addr[5+log2(NUM_LINES)-1:5]; tag = remaining upper bits.
- Lookup is combinational, in the IDLE state only.
  - Hit when the line's valid bit is set and its tag equals the address tag.
  - Hit: `Instr1_valid_fIC`=1 and `Instr1_fIC` = line word[word].
  - Hit with word < 7: `Instr2_valid_fIC`=1 and `Instr2_fIC` = word[word+1].
  - Hit with word = 7: `Instr2_valid_fIC`=0.
- Invalid outputs drive 0 on the instruction bus. Both valids are 0 on a miss and at all times while in FILL.
- FSM states: IDLE and FILL.
  - IDLE, miss: on the next edge, latch the aligned miss address, increment `miss_count`, go to FILL.
  - FILL: `iBlkRead`=1. `Instr_address_2IM` = latched address, held stable until `block_read_fIM_valid`.
  - FILL with `block_read_fIM_valid`=1: on that edge, write data and tag, set the valid bit, return to IDLE. The same PC then hits on the following cycle.
- IF changes `Instr_address_2IC` during FILL: the fill for the latched address still completes and is installed. Lookup then resumes on the current address.
- `Flush`: clears all valid bits at the next edge.
  - During FILL, the fill completes but its line is left invalid.
  - `Flush` and fill completion in the same cycle: flush wins and the line stays invalid.
  - In IDLE the lookup in the flush cycle is still combinational. The next cycle misses.
- `block_read_fIM_valid` in IDLE is ignored.
- In IDLE, `iBlkRead`=0 and `Instr_address_2IM` holds its last fill address.

## Timing
- Reset values (asynchronous, while RESET=0):
  - all valid bits 0, state IDLE, `iBlkRead` 0, `Instr_address_2IM` 0, `miss_count` 0;
  - both valids 0 and both instruction buses 0, because every lookup misses.
- Hit latency: 0 cycles; combinational from address to instruction.
- Miss penalty: 1 cycle (IDLE detect) + L cycles until `block_read_fIM_valid` + 1 cycle re-lookup.
- Memory valid in the first FILL cycle (L=1): the line is installed and the hit comes 2 cycles after the miss is detected.
- Reset asserted mid-FILL aborts the fill. `iBlkRead` drops immediately and no partial line is installed.
- Data and tag arrays are not reset. Only the valid bits are.

## Structure
- Package `icache_pkg`:
  - constants `BLOCK_WORDS`=8, `OFFSET_BITS`=5, `WORD_BITS`=3;
  - the state enum {IDLE, FILL};
  - address-split helper functions.
- One sub-module, `icache_line_store`, holds the data, tag and valid arrays:
  - one combinational read port;
  - one write port that writes a full line with tag;
  - one synchronous clear-all input.
- The top holds the FSM, the latched miss address, `miss_count` and the output muxing.

## Test plan
- Cold miss: reset, then PC=0x00400000 with memory L=3 (word i = 0x1000+i) → `iBlkRead`=1 and `Instr_address_2IM`=0x00400000 for 3 cycles. The next cycle gives `Instr1_fIC`=0x1000, `Instr2_fIC`=0x1001, both valid; `miss_count`=1.
- Line boundary: after the fill, PC=0x0040001C → `Instr1_fIC`=0x1007 valid, `Instr2_valid_fIC`=0, no new fill.
- Conflict eviction: with NUM_LINES=32, fetch 0x00400000, then 0x00400400 (same index), then 0x00400000 → three fills, `miss_count`=3, the final data comes from the first block.
- Flush: a hot line at 0x00400000 plus `Flush` pulsed in the same cycle as fill completion of 0x00400020 → both addresses miss afterwards and `miss_count` increments on each.
- PC change during FILL: miss on 0x00400040, PC switched to 0x00400000 (valid) mid-fill → the fill completes, then 0x00400000 hits immediately and 0x00400040 hits when revisited.
- Reset mid-FILL: RESET=0 with `iBlkRead`=1 → `iBlkRead`=0 asynchronously, `miss_count`=0, and the same PC misses again after release.
